sbox_array: RTL and testbench
=============================

SBOX_ARRAY -- requirements
Module: sbox_array

Interface
REQ-001 The block SHALL have parameter LANES, default 16, meaning the number of byte lanes per data word; legal values 1..16.
REQ-002 The block SHALL have parameter SHARE, default 4, meaning the number of physical S-box lookups per cycle; it SHALL divide LANES exactly.
REQ-003 The block SHALL have parameter INV_EN, default 1, where 1 builds the inverse table and 0 omits it.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_valid, input, 1 bit: input word present.
REQ-007 The block SHALL have port o_ready, output, 1 bit: block can accept a word.
REQ-008 The block SHALL have port i_data, input, 8*LANES bits: lane k occupies bits [8k+7:8k].
REQ-009 The block SHALL have port i_inv, input, 1 bit: 1 selects the inverse S-box, 0 selects forward; it SHALL be ignored when INV_EN=0.
REQ-010 The block SHALL have port i_abort, input, 1 bit: discards the word in progress.
REQ-011 The block SHALL have port o_valid, output, 1 bit: result word present.
REQ-012 The block SHALL have port i_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port o_data, output, 8*LANES bits: substituted word, with the same lane mapping as i_data.

Function
REQ-014 The block SHALL implement states IDLE, BUSY and DONE; N = LANES/SHARE; the chunk counter width is clog2(N), minimum 1 bit.
REQ-015 In IDLE, o_ready SHALL be 1; in BUSY and DONE, o_ready SHALL be 0.
REQ-016 Accept: on an edge with i_valid=1 in IDLE, the block SHALL capture i_data and the effective mode (i_inv and INV_EN), clear the counter to 0, and enter BUSY.
REQ-017 Each BUSY edge SHALL substitute chunk c (lanes c*SHARE .. c*SHARE+SHARE-1) of the captured word using the captured mode, write the result into the result register, and increment the counter.
REQ-018 On the BUSY edge where c = N-1, the block SHALL enter DONE and set o_valid=1; o_valid therefore rises exactly N edges after the accept edge.
REQ-019 When N=1, the block SHALL spend exactly one edge in BUSY.
REQ-020 In DONE, o_data and o_valid SHALL hold stable until an edge with i_ready=1; that edge SHALL clear o_valid and return the block to IDLE.
REQ-021 No new word SHALL be accepted in the same edge as a result handoff; throughput is one word per N+2 cycles, minimum.
REQ-022 Forward lookups SHALL use the AES SubBytes table; inverse lookups SHALL use the AES InvSubBytes table; every one of the 256 entries is defined, with no X or Z output.
REQ-023 i_abort=1 in BUSY SHALL return the block to IDLE on that edge with o_valid=0, and the partial result SHALL never be presented.
REQ-024 i_abort SHALL be ignored in IDLE and in DONE; in DONE, only i_ready releases the result.
REQ-025 Input changes on i_data or i_inv after the accept edge SHALL have no effect on the result in progress.
REQ-026 o_data SHALL change only on BUSY edges and reset; its value in IDLE is the last completed or partial result and is don't-care to consumers.

Reset
REQ-027 An edge with i_rst=1 SHALL force state IDLE, counter 0, o_valid=0, o_ready=1 and o_data=0, overriding every other input, including mid-BUSY and in DONE.
REQ-028 On the first edge after i_rst falls, the block SHALL be able to accept a word.

Verification
REQ-029 Forward, LANES=16/SHARE=4: i_data=128'h0F0E0D0C0B0A09080706050403020100, i_inv=0 -> o_valid rises 4 edges after accept; o_data=128'h76ABD7FE2B670130C56F6BF27B777C63.
REQ-030 Inverse round trip: feed the REQ-029 result with i_inv=1 -> o_data=128'h0F0E0D0C0B0A09080706050403020100.
REQ-031 Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and o_data stay stable, o_ready=0; release -> IDLE next edge.
REQ-032 Abort: assert i_abort at counter=2 -> o_valid never rises; the next word, with lanes all 8'h53, yields all 8'hED.
REQ-033 Reset mid-BUSY at counter=1 -> next edge o_valid=0, o_ready=1, o_data=0; the following word completes with correct latency.
REQ-034 Sweep: LANES=1/SHARE=1 and INV_EN=0, all 256 inputs with i_inv=1 -> forward results, e.g. 8'h00->8'h63 and 8'hFF->8'h16, latency 1.

Source files
------------

// File: rtl/sbox_array.sv
// sbox_array: time-multiplexed AES S-box substitution over a word of byte lanes.
//
// A word is accepted in IDLE, then processed SHARE lanes per cycle over
// N = LANES/SHARE BUSY cycles. The finished word is held in DONE until the
// consumer takes it.
//
// Parameters:
//   LANES  - byte lanes per word (1..16)
//   SHARE  - S-box lookups per cycle (must divide LANES)
//   INV_EN - 1 builds the inverse S-box path, 0 forces forward mode
// Ports:
//   i_clk, i_rst       - clock, synchronous active-high reset
//   i_valid / o_ready  - input handshake (o_ready high only in IDLE)
//   i_data, i_inv      - input word (lane k at [8k+7:8k]) and inverse select
//   i_abort            - drop the word in progress (BUSY only)
//   o_valid / i_ready  - output handshake
//   o_data             - substituted word, same lane mapping as i_data
module sbox_array #(
  parameter int LANES  = 16,
  parameter int SHARE  = 4,
  parameter int INV_EN = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [8*LANES-1:0] i_data,
  input  logic               i_inv,
  input  logic               i_abort,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [8*LANES-1:0] o_data
);

  localparam int N  = LANES / SHARE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [8*LANES-1:0] data_q, data_d;
  logic               inv_q, inv_d;
  logic [8*LANES-1:0] res_q, res_d;
  logic [8*LANES-1:0] res_sub_s;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      r = r ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);   // p = a^(2^i)
      r = gf_mul(r, p);   // accumulates a^(2+4+...+128) = a^254
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  // With INV_EN=0 the inverse branch is constant-false and drops out.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] x, input logic inv);
    logic [7:0] r;
    if (inv && (INV_EN != 0)) begin
      r = gf_inv(inv_affine(x));
    end else begin
      r = fwd_affine(gf_inv(x));
    end
    return r;
  endfunction

  // Substitute the current chunk of the captured word into a copy of the result.
  always_comb begin
    res_sub_s = res_q;
    for (int s = 0; s < SHARE; s++) begin
      res_sub_s[(int'(cnt_q) * SHARE + s) * 8 +: 8] =
        sbox_lookup(data_q[(int'(cnt_q) * SHARE + s) * 8 +: 8], inv_q);
    end
  end

  // Next-state, capture and handshake decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    inv_d   = inv_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d = S_BUSY;
          cnt_d   = {CW{1'b0}};
          data_d  = i_data;
          inv_d   = (INV_EN != 0) ? i_inv : 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // Abort leaves the result register untouched; o_valid never rises for it.
        if (i_abort) begin
          state_d = S_IDLE;
          cnt_d   = {CW{1'b0}};
        end else begin
          res_d = res_sub_s;
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = S_BUSY;
            cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
      end
      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
    valid_d = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      data_q  <= {(8*LANES){1'b0}};
      inv_q   <= 1'b0;
      res_q   <= {(8*LANES){1'b0}};
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = res_q;

endmodule

// File: tb/tb_sbox_array.sv
module tb_sbox_array;

  localparam int N_A = 4;

  logic         clk;
  logic         rst;
  // DUT A: 16 lanes, 4 lookups per cycle, inverse enabled
  logic         a_valid, a_ready, a_inv, a_abort, a_ovalid, a_iready;
  logic [127:0] a_data, a_odata;
  // DUT B: 1 lane, 1 lookup per cycle, inverse disabled
  logic         b_valid, b_ready, b_inv, b_abort, b_ovalid, b_iready;
  logic [7:0]   b_data, b_odata;

  int tests;
  int failed;

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  sbox_array #(.LANES(16), .SHARE(4), .INV_EN(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_ready),
    .i_data(a_data), .i_inv(a_inv), .i_abort(a_abort), .o_valid(a_ovalid),
    .i_ready(a_iready), .o_data(a_odata)
  );

  sbox_array #(.LANES(1), .SHARE(1), .INV_EN(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ready),
    .i_data(b_data), .i_inv(b_inv), .i_abort(b_abort), .o_valid(b_ovalid),
    .i_ready(b_iready), .o_data(b_odata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference tables from the generator-walk construction: p steps through
  // all nonzero elements by multiplying by 3, q tracks its inverse by dividing by 3.
  task automatic build_tables;
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      fwd_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    fwd_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);
  endtask

  function automatic logic [127:0] ref_word(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++)
      r[8*k +: 8] = inv ? inv_t[d[8*k +: 8]] : fwd_t[d[8*k +: 8]];
    return r;
  endfunction

  // Push one word through DUT A, checking latency, data, optional hold and handoff.
  task automatic run_a(input logic [127:0] d, input logic inv, input int hold,
                       input string nm, output logic [127:0] got);
    logic [127:0] exp_w;
    logic early, stable;
    int w;
    exp_w = ref_word(d, inv);
    w = 0;
    while (!a_ready && w < 20) begin tick; w++; end
    tests++;
    if (!a_ready) begin
      failed++;
      $display("FAIL %s_ready_wait: o_ready=%b required 1", nm, a_ready);
    end
    a_data = d; a_inv = inv; a_valid = 1'b1; a_iready = 1'b0;
    tick;
    a_valid = 1'b0;
    a_data = {$urandom, $urandom, $urandom, $urandom};
    a_inv = ~inv;
    tests++;
    if (a_ready !== 1'b0) begin
      failed++;
      $display("FAIL %s_busy_ready: o_ready=%b required 0", nm, a_ready);
    end
    early = 1'b0;
    for (int k = 1; k <= N_A; k++) begin
      tick;
      if (k < N_A && a_ovalid !== 1'b0) early = 1'b1;
    end
    tests++;
    if (early || a_ovalid !== 1'b1) begin
      failed++;
      $display("FAIL %s_latency: early=%b o_valid=%b required early=0 o_valid=1", nm, early, a_ovalid);
    end
    tests++;
    if (a_odata !== exp_w) begin
      failed++;
      $display("FAIL %s_data: got %h required %h", nm, a_odata, exp_w);
    end
    got = a_odata;
    if (hold > 0) begin
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        a_abort = 1'b1;
        tick;
        if (a_ovalid !== 1'b1 || a_ready !== 1'b0 || a_odata !== exp_w) stable = 1'b0;
      end
      a_abort = 1'b0;
      tests++;
      if (!stable) begin
        failed++;
        $display("FAIL %s_hold_stable: stable=%b required 1", nm, stable);
      end
    end
    a_iready = 1'b1;
    tick;
    a_iready = 1'b0;
    tests++;
    if (a_ovalid !== 1'b0 || a_ready !== 1'b1) begin
      failed++;
      $display("FAIL %s_handoff: o_valid=%b o_ready=%b required 0/1", nm, a_ovalid, a_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    tests++;
    if (a_ovalid !== 1'b0 || a_ready !== 1'b1 || a_odata !== 128'h0) begin
      failed++;
      $display("FAIL reset_a: v=%b r=%b d=%h required 0/1/0", a_ovalid, a_ready, a_odata);
    end
    tests++;
    if (b_ovalid !== 1'b0 || b_ready !== 1'b1 || b_odata !== 8'h00) begin
      failed++;
      $display("FAIL reset_b: v=%b r=%b d=%h required 0/1/0", b_ovalid, b_ready, b_odata);
    end
  endtask

  task automatic test_vector;
    logic [127:0] got;
    run_a(128'h0F0E0D0C0B0A09080706050403020100, 1'b0, 0, "vec_fwd", got);
    tests++;
    if (got !== 128'h76ABD7FE2B670130C56F6BF27B777C63) begin
      failed++;
      $display("FAIL vec_fwd_const: got %h required 76abd7fe2b670130c56f6bf27b777c63", got);
    end
    run_a(got, 1'b1, 0, "vec_inv", got);
    tests++;
    if (got !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      failed++;
      $display("FAIL vec_inv_const: got %h required 0f0e0d0c0b0a09080706050403020100", got);
    end
  endtask

  task automatic test_random;
    logic [127:0] got;
    for (int i = 0; i < 8; i++)
      run_a({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 0, "rand", got);
  endtask

  task automatic test_backpressure;
    logic [127:0] got;
    run_a({$urandom, $urandom, $urandom, $urandom}, 1'b0, 10, "bp", got);
  endtask

  task automatic test_abort;
    logic [127:0] got;
    logic seen;
    a_data = {$urandom, $urandom, $urandom, $urandom}; a_inv = 1'b0; a_valid = 1'b1;
    tick;
    a_valid = 1'b0;
    tick; tick;
    a_abort = 1'b1;
    tick;
    a_abort = 1'b0;
    tests++;
    if (a_ovalid !== 1'b0 || a_ready !== 1'b1) begin
      failed++;
      $display("FAIL abort_idle: o_valid=%b o_ready=%b required 0/1", a_ovalid, a_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (a_ovalid !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      failed++;
      $display("FAIL abort_no_valid: o_valid seen=%b required 0", seen);
    end
    run_a({16{8'h53}}, 1'b0, 0, "post_abort", got);
    tests++;
    if (got !== {16{8'hED}}) begin
      failed++;
      $display("FAIL post_abort_const: got %h required all ed", got);
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] got;
    a_data = {$urandom, $urandom, $urandom, $urandom}; a_inv = 1'b0; a_valid = 1'b1;
    tick;
    a_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests++;
    if (a_ovalid !== 1'b0 || a_ready !== 1'b1 || a_odata !== 128'h0) begin
      failed++;
      $display("FAIL reset_mid: v=%b r=%b d=%h required 0/1/0", a_ovalid, a_ready, a_odata);
    end
    run_a({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, "after_rst", got);
  endtask

  // With i_valid and i_ready held high, results must be N+2 cycles apart.
  task automatic test_back_to_back;
    logic [127:0] d, exp_w;
    int rises[$];
    logic bad;
    d = {$urandom, $urandom, $urandom, $urandom};
    exp_w = ref_word(d, 1'b0);
    a_data = d; a_inv = 1'b0; a_valid = 1'b1; a_iready = 1'b1;
    bad = 1'b0;
    for (int t = 0; t < 30; t++) begin
      tick;
      if (a_ovalid === 1'b1) begin
        rises.push_back(t);
        if (a_odata !== exp_w) bad = 1'b1;
      end
    end
    a_valid = 1'b0; a_iready = 1'b0;
    tick; tick;
    tests++;
    if (rises.size() < 2 || (rises[1] - rises[0]) != N_A + 2) begin
      failed++;
      $display("FAIL b2b_spacing: count=%0d spacing=%0d required spacing %0d",
               rises.size(), (rises.size() >= 2) ? rises[1] - rises[0] : -1, N_A + 2);
    end
    tests++;
    if (bad) begin
      failed++;
      $display("FAIL b2b_data: bad=%b required 0", bad);
    end
  endtask

  // DUT B: every byte, inverse requested but disabled, one-cycle latency.
  task automatic test_sweep;
    logic [7:0] got00, gotff;
    int bad_lat, bad_dat;
    bad_lat = 0; bad_dat = 0;
    got00 = 8'h00; gotff = 8'h00;
    for (int i = 0; i < 256; i++) begin
      b_data = 8'(i); b_inv = 1'b1; b_valid = 1'b1;
      tick;
      b_valid = 1'b0;
      b_data = 8'($urandom);
      if (b_ovalid !== 1'b0 || b_ready !== 1'b0) bad_lat++;
      tick;
      if (b_ovalid !== 1'b1) bad_lat++;
      if (b_odata !== fwd_t[i]) bad_dat++;
      if (i == 0) got00 = b_odata;
      if (i == 255) gotff = b_odata;
      b_iready = 1'b1;
      tick;
      b_iready = 1'b0;
    end
    tests++;
    if (bad_lat != 0) begin
      failed++;
      $display("FAIL sweep_latency: %0d bad cycles required 0", bad_lat);
    end
    tests++;
    if (bad_dat != 0) begin
      failed++;
      $display("FAIL sweep_data: %0d wrong bytes required 0", bad_dat);
    end
    tests++;
    if (got00 !== 8'h63 || gotff !== 8'h16) begin
      failed++;
      $display("FAIL sweep_ends: 00->%h ff->%h required 63/16", got00, gotff);
    end
  endtask

  initial begin
    tests = 0; failed = 0;
    rst = 1'b1;
    a_valid = 1'b0; a_inv = 1'b0; a_abort = 1'b0; a_iready = 1'b0; a_data = 128'h0;
    b_valid = 1'b0; b_inv = 1'b0; b_abort = 1'b0; b_iready = 1'b0; b_data = 8'h00;
    build_tables();
    test_reset();
    test_vector();
    test_random();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
